// File: rtl/sal_axi_chan_unit.sv
// sal_axi_chan_unit
//   AXI address-channel slave with an address FIFO forwarding to a downstream
//   request port, plus an AXI write-response (B) master fed by downstream
//   completions. An APB port enables the block and exposes status/counters.
//
//   Optional build macro: SAL_CHAN_PERF_CNT_EN
//     defined   -> A_CNT / B_CNT / ERR_CNT counters are implemented
//     undefined -> no counter flops; those addresses read 0 (writes still err)
//
//   Reset is asynchronous and active-high on rst_n (the name is historical).

module sal_axi_chan_unit #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int MAX_OUTST  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // APB control/status
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [11:0]           paddr,
    input  logic [31:0]           pwdata,
    output logic [31:0]           prdata,
    output logic                  pready,
    output logic                  pslverr,
    // AXI address channel (slave)
    input  logic                  avalid,
    output logic                  aready,
    input  logic [ID_WIDTH-1:0]   aid,
    input  logic [ADDR_WIDTH-1:0] aaddr,
    input  logic [7:0]            alen,
    input  logic [2:0]            asize,
    input  logic [1:0]            aburst,
    // downstream request port
    output logic                  req_valid,
    input  logic                  req_ready,
    output logic [ID_WIDTH-1:0]   req_id,
    output logic [ADDR_WIDTH-1:0] req_addr,
    output logic [7:0]            req_len,
    output logic [2:0]            req_size,
    output logic [1:0]            req_burst,
    // downstream completion port
    input  logic                  done_valid,
    output logic                  done_ready,
    input  logic [ID_WIDTH-1:0]   done_id,
    input  logic                  done_err,
    // AXI write response (master)
    output logic                  bvalid,
    input  logic                  bready,
    output logic [ID_WIDTH-1:0]   bid,
    output logic [1:0]            bresp
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam int EW = ID_WIDTH + ADDR_WIDTH + 8 + 3 + 2;

    localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);
    localparam logic [OW-1:0] MAX_OUTST_C = OW'(MAX_OUTST);

    localparam logic [11:0] ADDR_CTRL   = 12'h000;
    localparam logic [11:0] ADDR_STATUS = 12'h004;
    localparam logic [11:0] ADDR_A_CNT  = 12'h008;
    localparam logic [11:0] ADDR_B_CNT  = 12'h00C;
    localparam logic [11:0] ADDR_ERR    = 12'h010;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic          en_q;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [OW-1:0] outst_q, outst_d;

    logic                bvalid_q;
    logic [ID_WIDTH-1:0] bid_q;
    logic [1:0]          bresp_q;

    logic [EW-1:0] entry_w [DEPTH];
    logic [EW-1:0] push_data;
    logic [EW-1:0] head_data;

    logic fifo_full;
    logic fifo_empty;
    logic a_hs;
    logic pop;
    logic d_hs;
    logic b_hs;

    // ------------------------------------------------------------------
    // Handshakes. aready depends on registered state only, so a pop in
    // the same cycle never opens a full FIFO.
    // ------------------------------------------------------------------
    assign fifo_full  = (cnt_q == DEPTH_C);
    assign fifo_empty = (cnt_q == '0);

    assign aready     = en_q & ~fifo_full & (outst_q < MAX_OUTST_C);
    assign a_hs       = avalid & aready;

    assign req_valid  = ~fifo_empty;
    assign pop        = req_valid & req_ready;

    assign done_ready = ~bvalid_q | bready;
    assign d_hs       = done_valid & done_ready;
    assign b_hs       = bvalid_q & bready;

    // ------------------------------------------------------------------
    // Address FIFO storage: one register per entry, written at wr_ptr.
    // ------------------------------------------------------------------
    assign push_data = {aid, aaddr, alen, asize, aburst};

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [EW-1:0] entry_q;

            // capture the accepted request into this slot when it is the write target
            always_ff @(posedge clk) begin
                if (a_hs && (wr_ptr_q == PW'(gi))) begin
                    entry_q <= push_data;
                end
            end

            assign entry_w[gi] = entry_q;
        end
    endgenerate

    assign head_data = entry_w[rd_ptr_q];
    assign {req_id, req_addr, req_len, req_size, req_burst} = head_data;

    // FIFO pointer/occupancy next state; pointers wrap naturally since DEPTH is a power of 2
    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(a_hs);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        cnt_d    = cnt_q;
        case ({a_hs, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // outstanding count: +1 on A, -1 on B, saturating at zero on a stray B
    always_comb begin
        outst_d = outst_q;
        if (a_hs && !b_hs) begin
            outst_d = outst_q + OW'(1);
        end else if (b_hs && !a_hs && (outst_q != '0)) begin
            outst_d = outst_q - OW'(1);
        end
    end

    // FIFO pointers and outstanding counter registers
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            outst_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            outst_q  <= outst_d;
        end
    end

    // ------------------------------------------------------------------
    // B channel: a completion loads the response register; it holds until
    // bready. done_ready lets a new completion load in the same cycle the
    // old response is taken.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            bvalid_q <= 1'b0;
            bid_q    <= '0;
            bresp_q  <= RESP_OKAY;
        end else if (d_hs) begin
            bvalid_q <= 1'b1;
            bid_q    <= done_id;
            bresp_q  <= done_err ? RESP_SLVERR : RESP_OKAY;
        end else if (b_hs) begin
            bvalid_q <= 1'b0;
        end
    end

    assign bvalid = bvalid_q;
    assign bid    = bid_q;
    assign bresp  = bresp_q;

    // ------------------------------------------------------------------
    // APB decode
    // ------------------------------------------------------------------
    logic        apb_acc;
    logic        sel_ctrl;
    logic        sel_status;
    logic        sel_a_cnt;
    logic        sel_b_cnt;
    logic        sel_err;
    logic        mapped;
    logic        ctrl_wr;
    logic [31:0] rd_data;
    logic [31:0] status_w;
    logic [31:0] a_cnt_w;
    logic [31:0] b_cnt_w;
    logic [31:0] err_cnt_w;
    logic        unused_pwdata;

    assign apb_acc    = psel & penable;
    assign sel_ctrl   = (paddr == ADDR_CTRL);
    assign sel_status = (paddr == ADDR_STATUS);
    assign sel_a_cnt  = (paddr == ADDR_A_CNT);
    assign sel_b_cnt  = (paddr == ADDR_B_CNT);
    assign sel_err    = (paddr == ADDR_ERR);
    assign mapped     = sel_ctrl | sel_status | sel_a_cnt | sel_b_cnt | sel_err;

    // CTRL is the only writable register; every other mapped address is read-only
    assign ctrl_wr = apb_acc & pwrite & sel_ctrl;
    assign pslverr = apb_acc & (~mapped | (pwrite & ~sel_ctrl));
    assign pready  = 1'b1;

    // only CTRL.EN is stored from the write data
    assign unused_pwdata = ^pwdata[31:1];

    // enable bit: gates new A acceptance only, queued work keeps draining
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            en_q <= 1'b0;
        end else if (ctrl_wr) begin
            en_q <= pwdata[0];
        end
    end

    assign status_w = {14'd0, fifo_empty, fifo_full, 8'(outst_q), 8'(cnt_q)};

`ifdef SAL_CHAN_PERF_CNT_EN
    logic [31:0] a_cnt_q;
    logic [31:0] b_cnt_q;
    logic [31:0] err_cnt_q;

    // event counters, free-running and wrapping at 2^32
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            a_cnt_q   <= '0;
            b_cnt_q   <= '0;
            err_cnt_q <= '0;
        end else begin
            if (a_hs) begin
                a_cnt_q <= a_cnt_q + 32'd1;
            end
            if (b_hs) begin
                b_cnt_q <= b_cnt_q + 32'd1;
            end
            if (b_hs && (bresp_q == RESP_SLVERR)) begin
                err_cnt_q <= err_cnt_q + 32'd1;
            end
        end
    end

    assign a_cnt_w   = a_cnt_q;
    assign b_cnt_w   = b_cnt_q;
    assign err_cnt_w = err_cnt_q;
`else
    assign a_cnt_w   = 32'd0;
    assign b_cnt_w   = 32'd0;
    assign err_cnt_w = 32'd0;
`endif

    // read mux; unmapped addresses return 0
    always_comb begin
        rd_data = 32'd0;
        if (sel_ctrl) begin
            rd_data = {31'd0, en_q};
        end else if (sel_status) begin
            rd_data = status_w;
        end else if (sel_a_cnt) begin
            rd_data = a_cnt_w;
        end else if (sel_b_cnt) begin
            rd_data = b_cnt_w;
        end else if (sel_err) begin
            rd_data = err_cnt_w;
        end
    end

    assign prdata = apb_acc ? rd_data : 32'd0;

endmodule

// File: tb/tb_sal_axi_chan_unit.sv
// Testbench for sal_axi_chan_unit: directed steps followed by a randomized
// phase, every cycle compared against a transaction-level reference model
// (request queue, outstanding count, pending B response, counters).

module tb_sal_axi_chan_unit;

    localparam int IDW   = 4;
    localparam int AW    = 32;
    localparam int DEPTH = 4;
    localparam int MAXO  = 8;

`ifdef SAL_CHAN_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic           psel, penable, pwrite;
    logic [11:0]    paddr;
    logic [31:0]    pwdata, prdata;
    logic           pready, pslverr;
    logic           avalid, aready;
    logic [IDW-1:0] aid;
    logic [AW-1:0]  aaddr;
    logic [7:0]     alen;
    logic [2:0]     asize;
    logic [1:0]     aburst;
    logic           req_valid, req_ready;
    logic [IDW-1:0] req_id;
    logic [AW-1:0]  req_addr;
    logic [7:0]     req_len;
    logic [2:0]     req_size;
    logic [1:0]     req_burst;
    logic           done_valid, done_ready;
    logic [IDW-1:0] done_id;
    logic           done_err;
    logic           bvalid, bready;
    logic [IDW-1:0] bid;
    logic [1:0]     bresp;

    always #5 clk = ~clk;

    sal_axi_chan_unit #(
        .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .MAX_OUTST(MAXO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .avalid(avalid), .aready(aready), .aid(aid), .aaddr(aaddr),
        .alen(alen), .asize(asize), .aburst(aburst),
        .req_valid(req_valid), .req_ready(req_ready), .req_id(req_id),
        .req_addr(req_addr), .req_len(req_len), .req_size(req_size),
        .req_burst(req_burst),
        .done_valid(done_valid), .done_ready(done_ready), .done_id(done_id),
        .done_err(done_err),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp)
    );

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [AW-1:0]  addr;
        logic [7:0]     len;
        logic [2:0]     size;
        logic [1:0]     burst;
    } req_t;

    // reference model state
    req_t           mq[$];
    bit             m_en;
    int             m_outst;
    bit             m_bv;
    logic [IDW-1:0] m_bid;
    logic [1:0]     m_bresp;
    logic [31:0]    m_acnt, m_bcnt, m_ecnt;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_mapped(input logic [11:0] a);
        return (a == 12'h000) || (a == 12'h004) || (a == 12'h008) ||
               (a == 12'h00C) || (a == 12'h010);
    endfunction

    function automatic logic [31:0] m_reg(input logic [11:0] a);
        logic [31:0] v;
        v = 32'd0;
        if (a == 12'h000) v = {31'd0, m_en};
        else if (a == 12'h004)
            v = {14'd0, mq.size() == 0, mq.size() == DEPTH, 8'(m_outst), 8'(mq.size())};
        else if (PERF && a == 12'h008) v = m_acnt;
        else if (PERF && a == 12'h00C) v = m_bcnt;
        else if (PERF && a == 12'h010) v = m_ecnt;
        return v;
    endfunction

    // one clock: compare all outputs with the model, then advance the model
    task automatic step();
        bit   exp_ar, acc, a_hs, pop, d_hs, b_hs;
        req_t r;
        #1;
        exp_ar = m_en && (mq.size() < DEPTH) && (m_outst < MAXO);
        acc    = psel && penable;
        check("aready", 64'(aready), 64'(exp_ar));
        check("req_valid", 64'(req_valid), 64'(mq.size() != 0));
        if (mq.size() != 0)
            check("req_fields", 64'({req_id, req_addr, req_len, req_size, req_burst}), 64'(mq[0]));
        check("done_ready", 64'(done_ready), 64'(!m_bv || bready));
        check("bvalid", 64'(bvalid), 64'(m_bv));
        check("bid", 64'(bid), 64'(m_bid));
        check("bresp", 64'(bresp), 64'(m_bresp));
        check("pready", 64'(pready), 64'(1));
        if (!(acc && pwrite))
            check("prdata", 64'(prdata), 64'(acc ? m_reg(paddr) : 32'd0));
        check("pslverr", 64'(pslverr),
              64'(acc && (!m_mapped(paddr) || (pwrite && paddr != 12'h000))));

        a_hs = avalid && exp_ar;
        pop  = (mq.size() != 0) && req_ready;
        d_hs = done_valid && (!m_bv || bready);
        b_hs = m_bv && bready;
        r    = {aid, aaddr, alen, asize, aburst};

        @(posedge clk);
        if (pop) void'(mq.pop_front());
        if (a_hs) begin
            mq.push_back(r);
            m_acnt++;
        end
        if (b_hs) begin
            m_bcnt++;
            if (m_bresp == 2'b10) m_ecnt++;
        end
        if (a_hs && !b_hs) m_outst++;
        else if (b_hs && !a_hs && m_outst > 0) m_outst--;
        if (d_hs) begin
            m_bv    = 1'b1;
            m_bid   = done_id;
            m_bresp = done_err ? 2'b10 : 2'b00;
        end else if (b_hs) begin
            m_bv = 1'b0;
        end
        if (acc && pwrite && paddr == 12'h000) m_en = pwdata[0];
        #1;
    endtask

    task automatic apb(input bit wr, input logic [11:0] a, input logic [31:0] d,
                       input string tag, input logic [31:0] exp_rd, input bit exp_err);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        step();
        penable = 1'b1;
        #1;
        if (!wr) check({tag, "_prdata"}, 64'(prdata), 64'(exp_rd));
        check({tag, "_pslverr"}, 64'(pslverr), 64'(exp_err));
        step();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic rand_a();
        aid    = IDW'($urandom);
        aaddr  = $urandom;
        alen   = 8'($urandom);
        asize  = 3'($urandom);
        aburst = 2'($urandom);
    endtask

    logic [11:0] addr_tab [6];

    initial begin
        addr_tab = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010, 12'h020};
        psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
        avalid = 0; aid = 0; aaddr = 0; alen = 0; asize = 0; aburst = 0;
        req_ready = 0; done_valid = 0; done_id = 0; done_err = 0; bready = 0;
        m_en = 0; m_outst = 0; m_bv = 0; m_bid = 0; m_bresp = 0;
        m_acnt = 0; m_bcnt = 0; m_ecnt = 0;

        // reset state
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_aready", 64'(aready), 64'(0));
        check("rst_req_valid", 64'(req_valid), 64'(0));
        check("rst_bvalid", 64'(bvalid), 64'(0));
        check("rst_bid", 64'(bid), 64'(0));
        check("rst_bresp", 64'(bresp), 64'(0));
        check("rst_prdata", 64'(prdata), 64'(0));
        check("rst_pslverr", 64'(pslverr), 64'(0));
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;

        // status after reset, A blocked while disabled
        apb(0, 12'h004, 0, "status_reset", 32'h0002_0000, 0);
        avalid = 1'b1;
        #1;
        check("aready_disabled", 64'(aready), 64'(0));
        step();
        avalid = 1'b0;

        // enable, single request passes through unmodified
        apb(1, 12'h000, 32'h1, "ctrl_en", 0, 0);
        apb(0, 12'h000, 0, "ctrl_rd", 32'h1, 0);
        avalid = 1; aid = 0; aaddr = 0; alen = 1; asize = 4; aburst = 1;
        step();
        avalid = 0;
        #1;
        check("first_req_valid", 64'(req_valid), 64'(1));
        check("first_req_fields", 64'({req_id, req_addr, req_len, req_size, req_burst}),
              64'({4'd0, 32'd0, 8'd1, 3'd4, 2'd1}));
        apb(0, 12'h008, 0, "a_cnt_1", PERF ? 32'd1 : 32'd0, 0);

        // fill the FIFO with downstream stalled
        for (int i = 0; i < 3; i++) begin
            avalid = 1; rand_a();
            step();
        end
        #1;
        check("aready_full", 64'(aready), 64'(0));
        step();
        avalid = 0;
        apb(0, 12'h004, 0, "status_full", 32'h0001_0404, 0);
        req_ready = 1;
        step();
        req_ready = 0;
        #1;
        check("aready_after_pop", 64'(aready), 64'(1));
        step();
        req_ready = 1;
        repeat (5) step();
        req_ready = 0;

        // B held under back-pressure, second completion stalls
        done_valid = 1; done_id = 0; done_err = 0; bready = 0;
        step();
        done_id = 5;
        #1;
        check("b_hold_valid", 64'(bvalid), 64'(1));
        check("b_hold_id", 64'(bid), 64'(0));
        check("b_hold_resp", 64'(bresp), 64'(0));
        check("done_stall", 64'(done_ready), 64'(0));
        repeat (2) step();
        bready = 1;
        step();
        done_valid = 0;
        #1;
        check("b_back2back_id", 64'(bid), 64'(5));
        step();
        bready = 0;
        step();

        // error completion
        done_valid = 1; done_id = 3; done_err = 1;
        step();
        done_valid = 0; done_err = 0;
        #1;
        check("bresp_err", 64'(bresp), 64'(2'b10));
        bready = 1;
        step();
        bready = 0;
        apb(0, 12'h010, 0, "err_cnt", PERF ? 32'd1 : 32'd0, 0);
        apb(0, 12'h00C, 0, "b_cnt", PERF ? 32'd3 : 32'd0, 0);

        // APB errors leave state untouched
        apb(1, 12'h008, 32'h1234, "wr_ro", 0, 1);
        apb(0, 12'h020, 0, "rd_unmapped", 0, 1);
        apb(1, 12'h004, 32'hFFFF_FFFF, "wr_status", 0, 1);
        apb(0, 12'h008, 0, "a_cnt_after_err", PERF ? 32'd4 : 32'd0, 0);

        // outstanding limit
        req_ready = 1;
        for (int i = 0; i < 20 && m_outst < MAXO; i++) begin
            avalid = 1; rand_a();
            step();
        end
        avalid = 1;
        #1;
        check("aready_outst_max", 64'(aready), 64'(0));
        step();
        avalid = 0;
        repeat (4) step();
        apb(0, 12'h004, 0, "status_outst8", 32'h0002_0800, 0);

        // randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            avalid     = ($urandom_range(0, 2) != 0);
            rand_a();
            req_ready  = ($urandom_range(0, 2) != 0);
            done_valid = ($urandom_range(0, 3) == 0);
            done_id    = IDW'($urandom);
            done_err   = ($urandom_range(0, 3) == 0);
            bready     = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 7) == 0) begin
                psel    = 1; penable = 1;
                pwrite  = ($urandom_range(0, 3) == 0);
                paddr   = addr_tab[$urandom_range(0, 5)];
                pwdata  = ($urandom_range(0, 3) == 0) ? 32'h0 : 32'h1;
            end else begin
                psel = 0; penable = 0; pwrite = 0;
            end
            step();
        end
        psel = 0; penable = 0; pwrite = 0;
        avalid = 0; done_valid = 0; req_ready = 1; bready = 1;
        repeat (12) step();
        apb(0, 12'h008, 0, "final_a_cnt", PERF ? m_acnt : 32'd0, 0);
        apb(0, 12'h00C, 0, "final_b_cnt", PERF ? m_bcnt : 32'd0, 0);
        apb(0, 12'h010, 0, "final_err_cnt", PERF ? m_ecnt : 32'd0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sal_axi_chan_unit.md
Name: sal_axi_chan_unit

Overview:
- AXI address-channel slave plus AXI write-response (B) master, with an APB control/status port.
- Address requests (AW or AR style) are buffered in a FIFO and forwarded to a downstream request port.
- Downstream completions are returned as B responses.
- Sits between the AXI front end and the DDR scheduler; APB enables the block and exposes counters.

Parameters:
ID_WIDTH, 4, AXI ID width
ADDR_WIDTH, 32, AXI address width
DEPTH, 4, address FIFO entries (power of 2, >=2)
MAX_OUTST, 8, maximum accepted-but-unresponded requests

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-high
psel  in  1  APB select
penable  in  1  APB enable
pwrite  in  1  APB write
paddr  in  12  APB byte address
pwdata  in  32  APB write data
prdata  out  32  APB read data
pready  out  1  APB ready, tied 1
pslverr  out  1  APB error
avalid  in  1  AXI address valid
aready  out  1  AXI address ready
aid  in  ID_WIDTH  AXI ID
aaddr  in  ADDR_WIDTH  AXI address
alen  in  8  burst length-1
asize  in  3  beat size
aburst  in  2  burst type
req_valid  out  1  downstream request valid
req_ready  in  1  downstream request ready
req_id/req_addr/req_len/req_size/req_burst  out  as A fields  forwarded request
done_valid  in  1  completion valid
done_ready  out  1  completion accepted
done_id  in  ID_WIDTH  completion ID
done_err  in  1  completion error
bvalid  out  1  B valid
bready  in  1  B ready
bid  out  ID_WIDTH  B ID
bresp  out  2  B response

Behaviour:
- Reset (rst_n=1, asynchronous): FIFO empty; CTRL.EN=0; all counters 0; aready=0; req_valid=0; bvalid=0; bid=0; bresp=0; prdata=0; pslverr=0.
- aready = EN & !fifo_full & (outst < MAX_OUTST), computed from registered state only. A pop in the same cycle does not open a full FIFO.
- A handshake (avalid&aready) pushes {aid,aaddr,alen,asize,aburst}. The entry appears on req_* the next cycle.
- req_valid = !fifo_empty; req_* show the head entry. Pop on req_valid&req_ready.
- Push and pop in the same cycle are allowed when the FIFO is neither full nor empty. Pointers wrap modulo DEPTH.
- Requests are forwarded in acceptance order. Fields pass through unmodified.
- done_ready = !bvalid | bready.
- On done_valid&done_ready: bvalid<=1, bid<=done_id, bresp<=done_err?2'b10:2'b00, registered one cycle.
- bvalid holds with stable bid/bresp until bready. Back-to-back B is possible: a new completion is loaded in the same cycle the old one is taken.
- outst: +1 on A handshake, -1 on B handshake, unchanged when both occur. Never underflows; a B handshake at outst=0 leaves it at 0.
- Clearing EN stops new A acceptance only. Queued requests and responses drain normally.
- APB:
  - Zero-wait. Writes take effect on psel&penable&pwrite. prdata is driven combinationally during the access phase and is 0 otherwise.
  - pslverr=1 in the access phase for unmapped addresses, or for a write to a read-only register; such writes have no effect.
- Register map:
  - 0x00 CTRL RW: bit0 EN, other bits read 0.
  - 0x04 STATUS RO: [7:0] fifo count, [15:8] outst, bit16 fifo_full, bit17 fifo_empty.
  - 0x08 A_CNT RO: accepted A count.
  - 0x0C B_CNT RO: issued B count.
  - 0x10 ERR_CNT RO: B handshakes with bresp=2'b10.
- Counters are 32-bit and wrap at 2^32.

Optional Feature:
- SAL_CHAN_PERF_CNT_EN:
  - Defined: A_CNT, B_CNT and ERR_CNT are implemented.
  - Undefined: no counter flops; addresses 0x08/0x0C/0x10 read 0 with pslverr=0, and writes to them still return pslverr=1.

Test Plan:
- Reset then APB read 0x04 -> prdata=0x0002_0000 (empty). aready=0 with avalid=1 while EN=0.
- APB write 0x00=1; A aid=0, aaddr=0x0, alen=1, asize=4, aburst=1 -> req_valid next cycle with identical fields. A_CNT=1.
- req_ready=0, push 4 requests -> fifo_full=1, aready=0. Pop one -> aready=1 the following cycle.
- done_valid with done_id=0, done_err=0 and bready=0 -> bvalid=1, bid=0, bresp=00 held. Second completion stalls (done_ready=0) until bready.
- done_err=1 -> bresp=2'b10, ERR_CNT increments to 1.
- APB write to 0x08 or read of 0x20 -> pslverr=1, no state change. Issue 8 A requests with no B -> aready=0 (outst=8).
